// File: rtl/pigro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pigro_pkg
// Description : Shared PIGRO pipeline widths, opcode constants and the
//               layout of a writeback trace record body.
// Revision    : 1.0 - initial release
// ============================================================================
package pigro_pkg;

    localparam int OPC_W   = 5;
    localparam int PC_W    = 5;
    localparam int RADDR_W = 4;
    localparam int DATA_W  = 32;

    // Load opcode: the retired value comes from memory, not the ALU
    localparam logic [OPC_W-1:0] OP_LOAD = 5'd3;

    // Trace record body, MSB first: {pc, opcode, dest, result}.
    // The full record prepends the capture timestamp above this body.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [OPC_W-1:0]   opcode;
        logic [RADDR_W-1:0] dest;
        logic [DATA_W-1:0]  result;
    } rec_body_t;

    localparam int BODY_W = PC_W + OPC_W + RADDR_W + DATA_W;

    // Value the instruction actually wrote back
    function automatic logic [DATA_W-1:0] select_result(
        input logic [OPC_W-1:0]  opcode,
        input logic [DATA_W-1:0] aluout,
        input logic [DATA_W-1:0] lmdout
    );
        return (opcode == OP_LOAD) ? lmdout : aluout;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Generic synchronous FIFO with push/pop/flush. A push while
//               full is accepted only when a pop frees a slot the same edge.
//               Full/empty are decoded from the occupancy register.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head is read straight from storage; empty reads as zero
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; flush behaves like a soft reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_trace.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace
// Description : Writeback retirement trace buffer. Captures each retired
//               instruction as a timestamped record, queues it in a FIFO and
//               drains it over a valid/ready port. Never back-pressures the
//               pipeline: records arriving to a full FIFO are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace
    import pigro_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   e_WB,
    input  logic [PC_W-1:0]        pc_WB,
    input  logic [OPC_W-1:0]       opcode_WB,
    input  logic [RADDR_W-1:0]     destaddr_WB,
    input  logic [DATA_W-1:0]      aluout_WB,
    input  logic [DATA_W-1:0]      lmdout_WB,
    input  logic                   flush,
    output logic                   t_valid,
    input  logic                   t_ready,
    output logic [TS_W+BODY_W-1:0] t_data,
    output logic [CNT_W-1:0]       t_count,
    output logic [7:0]             dropped,
    output logic                   overflow
);

    localparam int REC_W = TS_W + BODY_W;

    logic [TS_W-1:0]  ts_ctr;
    rec_body_t        body;
    logic [REC_W-1:0] record;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;

    assign push = e_WB & ~flush;
    assign pop  = t_valid & t_ready;
    // Lost only when full and nothing leaves on the same edge
    assign drop = push & full & ~pop;

    assign t_valid = ~empty;

    always_comb begin
        body        = '0;
        body.pc     = pc_WB;
        body.opcode = opcode_WB;
        body.dest   = destaddr_WB;
        body.result = select_result(opcode_WB, aluout_WB, lmdout_WB);
    end

    assign record = {ts_ctr, body};

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_ctr <= '0;
        end else begin
            ts_ctr <= ts_ctr + TS_W'(1);
        end
    end

    // Drop accounting: saturating counter and sticky flag, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped  <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            if (dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
            overflow <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (record),
        .rd_data (t_data),
        .full    (full),
        .empty   (empty),
        .count   (t_count)
    );

endmodule
`default_nettype wire

// File: doc/wb_trace.md
# wb_trace

Writeback retirement trace buffer for the PIGRO 5-stage pipeline. Sits directly downstream of the writeback stage, consuming its per-instruction outputs (PC, opcode, destination, ALU result, load data, enable). Each retired instruction is captured as a timestamped trace record into a FIFO and drained through a valid/ready port toward a debug or logging consumer. Overflow is counted, never stalls the pipeline.

## Interface
Parameters:
- DEPTH, 8: FIFO entries, power of two, ≥2
- TS_W, 16: timestamp width
- CNT_W, $clog2(DEPTH+1): occupancy width (4 at default)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock, synchronous, active-high
- e_WB  in  1  writeback valid; record captured when high
- pc_WB  in  5  retired instruction PC
- opcode_WB  in  5  retired opcode
- destaddr_WB  in  4  destination register
- aluout_WB  in  32  ALU result
- lmdout_WB  in  32  load memory data
- flush  in  1  discard all buffered records
- t_valid  out  1  head record available
- t_ready  in  1  consumer accepts head record
- t_data  out  TS_W+46  {ts, pc, opcode, dest, result}; 62 bits at default
- t_count  out  CNT_W  records held
- dropped  out  8  records lost to full FIFO, saturates at 255
- overflow  out  1  sticky; set on first drop

## Operation
- Free-running cycle counter ts_ctr (TS_W), +1 every cycle, wraps to 0; record ts = ts_ctr value at capture edge.
- result = lmdout_WB if opcode_WB == OP_LOAD, else aluout_WB.
- push = e_WB & ~flush; pop = t_valid & t_ready.
- push accepted if not full, or if full and pop same cycle.
- push when full without pop: record dropped; dropped +1 (saturating at 255); overflow set.
- flush: read/write pointers and count to 0 next edge; same-cycle push discarded, not counted as dropped; same-cycle pop has no extra effect. dropped/overflow cleared only by rst.
- Records leave in capture order; t_data is stable while t_valid & ~t_ready.
- No bypass: push into empty FIFO shows t_valid next cycle.
- Reset values: t_valid 0, t_count 0, dropped 0, overflow 0, ts_ctr 0, pointers 0; t_data don't-care (driven 0).
- rst mid-operation: all buffered records lost; rst dominates flush, push, pop.

## Timing
- Capture latency: e_WB high at edge N → record at head, t_valid high, after edge N (visible cycle N+1) if FIFO was empty.
- Pop: t_valid & t_ready at edge N → next record (or t_valid 0) after edge N.
- t_count updates on the same edge as push/pop: +1, −1, or unchanged on simultaneous push+pop.
- Full + push + pop: count stays DEPTH, no drop.
- Empty + pop attempt: impossible by definition (t_valid 0).
- Pointers are log2(DEPTH) bits, wrap naturally; full/empty derived from count register.
- All outputs registered or decoded from registers only; no combinational path from e_WB or t_ready to outputs.

## Structure
- pigro_pkg: OPC_W=5, PC_W=5, RADDR_W=4, DATA_W=32, OP_LOAD opcode constant, trace record struct/field offsets.
- One sub-module: trace_fifo (generic synchronous FIFO, WIDTH/DEPTH params, push/pop/flush, full/empty/count); wb_trace holds timestamp counter, result select, drop/overflow logic.

## Test plan
- Reset, then 3 pushes (pc 1,2,3, aluout 32'h10/20/30), t_ready 0 → t_count 3; raise t_ready → records drain in order pc 1,2,3, t_valid 0 after third.
- opcode=OP_LOAD, lmdout=32'hCAFE0001, aluout=32'h00000010 → result field 32'hCAFE0001; other opcode → 32'h00000010.
- 10 consecutive pushes, t_ready 0, DEPTH 8 → t_count 8, dropped 2, overflow 1; drained records are pushes 1–8.
- Full FIFO, push with t_ready 1 same cycle → t_count stays 8, dropped unchanged, new record last out.
- flush with e_WB 1 same cycle, 5 held → t_count 0, t_valid 0 next cycle, dropped unchanged; rst with 4 held, overflow 1 → all outputs at reset values next cycle.
- Hold ts_ctr to 16'hFFFF then push two back-to-back → timestamps 16'hFFFF, 16'h0000.
